// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: default widths, register
// addresses, DMA state encoding and the DMA source address helper.
package bus_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int REG_WIDTH_DEF  = 8;

    localparam logic [15:0] OAM_DMA_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

    localparam int PAGE_WIDTH = 8;
    localparam int IDX_WIDTH  = 8;

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = 8'hFF;

    // DMA sequencer states; IDLE must stay the reset encoding
    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;

    // Source byte address of a DMA read: page selects the 256-byte block
    function automatic logic [PAGE_WIDTH+IDX_WIDTH-1:0] dma_src_addr(
        input logic [PAGE_WIDTH-1:0] page,
        input logic [IDX_WIDTH-1:0]  idx
    );
        return {page, idx};
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/memory side signals of the bus arbiter. The slave modport is
// the arbiter's view, the master modport the view of the surrounding system.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int REG_WIDTH  = REG_WIDTH_DEF
);

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_gnt;

    logic                  exec_req;
    logic                  exec_we;
    logic [ADDR_WIDTH-1:0] exec_addr;
    logic [REG_WIDTH-1:0]  exec_wdata;
    logic                  exec_gnt;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_wdata;
    logic                  mem_we;
    logic [REG_WIDTH-1:0]  mem_rdata;
    logic [REG_WIDTH-1:0]  rdata;

    logic                  cpu_halt;
    logic                  dma_busy;

    modport slave (
        input  fetch_req, fetch_addr,
        input  exec_req, exec_we, exec_addr, exec_wdata,
        input  mem_rdata,
        output fetch_gnt, exec_gnt,
        output mem_addr, mem_wdata, mem_we, rdata,
        output cpu_halt, dma_busy
    );

    modport master (
        output fetch_req, fetch_addr,
        output exec_req, exec_we, exec_addr, exec_wdata,
        output mem_rdata,
        input  fetch_gnt, exec_gnt,
        input  mem_addr, mem_wdata, mem_we, rdata,
        input  cpu_halt, dma_busy
    );

endinterface

// File: rtl/bus_arbiter_oam_dma.sv
// OAM DMA sequencer: once started, halts the CPU, aligns to an even cycle
// and copies 256 bytes from page:00..page:FF to the OAM data register,
// one read cycle and one write cycle per byte.
module oam_dma
    import bus_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int                    REG_WIDTH     = REG_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = ADDR_WIDTH'(OAM_DATA_ADDR_DEF)
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [PAGE_WIDTH-1:0] page_i,
    input  logic [REG_WIDTH-1:0]  mem_rdata_i,
    output logic                  busy_o,
    output logic                  bus_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [REG_WIDTH-1:0]  wdata_o,
    output logic                  we_o
);

    dma_state_t            state_q, state_d;
    logic                  cycle_odd_q;
    logic [PAGE_WIDTH-1:0] page_q, page_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [REG_WIDTH-1:0]  byte_q, byte_d;

    // Sequencer registers and the free-running cycle parity
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DMA_IDLE;
            cycle_odd_q <= 1'b0;
            page_q      <= {PAGE_WIDTH{1'b0}};
            idx_q       <= {IDX_WIDTH{1'b0}};
            byte_q      <= {REG_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cycle_odd_q <= ~cycle_odd_q;
            page_q      <= page_d;
            idx_q       <= idx_d;
            byte_q      <= byte_d;
        end
    end

    // Next state: HALT goes straight to READ only when the next cycle is even
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        case (state_q)
            DMA_IDLE: begin
                if (start_i) begin
                    state_d = DMA_HALT;
                    page_d  = page_i;
                end else begin
                    state_d = DMA_IDLE;
                end
            end
            DMA_HALT: begin
                if (cycle_odd_q) begin
                    state_d = DMA_READ;
                end else begin
                    state_d = DMA_ALIGN;
                end
            end
            DMA_ALIGN: begin
                state_d = DMA_READ;
            end
            DMA_READ: begin
                byte_d  = mem_rdata_i;
                state_d = DMA_WRITE;
            end
            DMA_WRITE: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == IDX_LAST) begin
                    state_d = DMA_IDLE;
                end else begin
                    state_d = DMA_READ;
                end
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // Bus request of the sequencer; only READ and WRITE own the memory bus
    always_comb begin
        busy_o  = (state_q != DMA_IDLE);
        bus_o   = 1'b0;
        addr_o  = {ADDR_WIDTH{1'b0}};
        wdata_o = byte_q;
        we_o    = 1'b0;
        case (state_q)
            DMA_READ: begin
                bus_o  = 1'b1;
                addr_o = ADDR_WIDTH'(dma_src_addr(page_q, idx_q));
            end
            DMA_WRITE: begin
                bus_o  = 1'b1;
                addr_o = OAM_DATA_ADDR;
                we_o   = 1'b1;
            end
            default: begin
                bus_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Fixed-priority memory bus arbiter (DMA > exec > fetch) with the OAM DMA
// trigger decode. Grants and the memory mux are combinational.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int                    REG_WIDTH     = REG_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] OAM_DMA_ADDR  = ADDR_WIDTH'(OAM_DMA_ADDR_DEF),
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = ADDR_WIDTH'(OAM_DATA_ADDR_DEF)
) (
    input  logic         phi1,
    input  logic         reset_n,
    bus_arbiter_if.slave bus
);

    logic                  run_q;
    logic                  trig_s;
    logic                  dma_start_s;
    logic                  dma_busy_s;
    logic                  dma_bus_s;
    logic [ADDR_WIDTH-1:0] dma_addr_s;
    logic [REG_WIDTH-1:0]  dma_wdata_s;
    logic                  dma_we_s;
    logic                  fetch_gnt_s;
    logic                  exec_gnt_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [REG_WIDTH-1:0]  mem_wdata_s;
    logic                  mem_we_s;

    oam_dma #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .REG_WIDTH     (REG_WIDTH),
        .OAM_DATA_ADDR (OAM_DATA_ADDR)
    ) u_oam_dma (
        .phi1        (phi1),
        .reset_n     (reset_n),
        .start_i     (dma_start_s),
        .page_i      (bus.exec_wdata[7:0]),
        .mem_rdata_i (bus.mem_rdata),
        .busy_o      (dma_busy_s),
        .bus_o       (dma_bus_s),
        .addr_o      (dma_addr_s),
        .wdata_o     (dma_wdata_s),
        .we_o        (dma_we_s)
    );

    // Arbitration is held off until the first clock edge after reset release
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Priority mux; a write to the DMA register is consumed, not forwarded
    always_comb begin
        fetch_gnt_s = 1'b0;
        exec_gnt_s  = 1'b0;
        dma_start_s = 1'b0;
        mem_addr_s  = bus.fetch_addr;
        mem_wdata_s = bus.exec_wdata;
        mem_we_s    = 1'b0;
        trig_s      = bus.exec_we && (bus.exec_addr == OAM_DMA_ADDR);
        if (!run_q) begin
            fetch_gnt_s = 1'b0;
        end else if (dma_busy_s) begin
            if (dma_bus_s) begin
                mem_addr_s  = dma_addr_s;
                mem_wdata_s = dma_wdata_s;
                mem_we_s    = dma_we_s;
            end else begin
                mem_we_s = 1'b0;
            end
        end else if (bus.exec_req) begin
            exec_gnt_s  = 1'b1;
            mem_addr_s  = bus.exec_addr;
            mem_we_s    = bus.exec_we && !trig_s;
            dma_start_s = trig_s;
        end else if (bus.fetch_req) begin
            fetch_gnt_s = 1'b1;
        end else begin
            fetch_gnt_s = 1'b0;
        end
    end

    assign bus.fetch_gnt = fetch_gnt_s;
    assign bus.exec_gnt  = exec_gnt_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.cpu_halt  = dma_busy_s;
    assign bus.dma_busy  = dma_busy_s;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: arbitration cases, DMA trigger with both
// halt parities, DMA interrupted by reset. DMA cycles are checked against
// a queue of expected per-cycle bus states filled when the DMA is started.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    typedef struct packed {
        logic        halt;
        logic        busy;
        logic        fgnt;
        logic        egnt;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } obs_t;

    typedef struct {
        obs_t v;
        bit   addr_dc;
        bit   data_dc;
    } exp_t;

    logic phi1    = 1'b0;
    logic reset_n = 1'b0;
    logic m_odd   = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   halted  = 0;
    exp_t exp_q[$];

    bus_arbiter_if bus ();

    bus_arbiter dut (
        .phi1    (phi1),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 phi1 = ~phi1;

    // Async-read memory contents as seen by the bench
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        if (a == 16'h8000) return 8'hA9;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign bus.mem_rdata = mem_model(bus.mem_addr);

    // Reference cycle parity
    always @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) m_odd <= 1'b0;
        else          m_odd <= ~m_odd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.halt  = bus.cpu_halt;
        o.busy  = bus.dma_busy;
        o.fgnt  = bus.fetch_gnt;
        o.egnt  = bus.exec_gnt;
        o.we    = bus.mem_we;
        o.addr  = bus.mem_addr;
        o.wdata = bus.mem_wdata;
        return o;
    endfunction

    function automatic void push_cycle(input logic we, input logic [15:0] addr,
                                       input logic [7:0] wdata, input bit adc, input bit ddc);
        exp_t e;
        e.v       = '{halt: 1'b1, busy: 1'b1, fgnt: 1'b0, egnt: 1'b0, we: we, addr: addr, wdata: wdata};
        e.addr_dc = adc;
        e.data_dc = ddc;
        exp_q.push_back(e);
    endfunction

    // Expected cycle-by-cycle bus activity of one complete DMA
    function automatic void push_dma(input logic [7:0] page, input bit halt_even);
        logic [15:0] a;
        push_cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
        if (halt_even) push_cycle(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            a = {page, 8'(i)};
            push_cycle(1'b0, a, 8'h00, 1'b0, 1'b1);
            push_cycle(1'b1, 16'h2004, mem_model(a), 1'b0, 1'b0);
        end
    endfunction

    // Pop and compare up to n expected DMA cycles, one per clock
    task automatic run_sb(input int n);
        exp_t e;
        obs_t o;
        for (int k = 0; k < n && exp_q.size() > 0; k++) begin
            #1;
            e = exp_q.pop_front();
            o = sample();
            if (o.halt) halted++;
            if (e.addr_dc) begin o.addr = 16'h0000; e.v.addr = 16'h0000; end
            if (e.data_dc) begin o.wdata = 8'h00; e.v.wdata = 8'h00; end
            chk($sformatf("dma_cycle%0d", k), 32'(o), 32'(e.v));
            tick();
        end
    endtask

    task automatic wait_parity(input logic want);
        for (int k = 0; k < 4 && m_odd !== want; k++) tick();
        chk("parity_wait", 32'(m_odd), 32'(want));
    endtask

    task automatic trigger(input logic [7:0] page);
        bus.exec_req   = 1'b1;
        bus.exec_we    = 1'b1;
        bus.exec_addr  = 16'h4014;
        bus.exec_wdata = page;
        #1;
        chk("trig_egnt", 32'(bus.exec_gnt), 32'd1);
        chk("trig_we",   32'(bus.mem_we),   32'd0);
        chk("trig_fgnt", 32'(bus.fetch_gnt), 32'd0);
        tick();
        bus.exec_req = 1'b0;
        bus.exec_we  = 1'b0;
    endtask

    initial begin
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h8000;
        bus.exec_req   = 1'b0;
        bus.exec_we    = 1'b0;
        bus.exec_addr  = 16'h0000;
        bus.exec_wdata = 8'h00;
        repeat (2) @(posedge phi1);
        #1;
        chk("rst_halt", 32'(bus.cpu_halt),  32'd0);
        chk("rst_busy", 32'(bus.dma_busy),  32'd0);
        chk("rst_fgnt", 32'(bus.fetch_gnt), 32'd0);
        chk("rst_egnt", 32'(bus.exec_gnt),  32'd0);
        chk("rst_we",   32'(bus.mem_we),    32'd0);
        reset_n = 1'b1;
        #1;
        chk("pre_edge_fgnt", 32'(bus.fetch_gnt), 32'd0);

        // fetch read
        tick(); #1;
        chk("fetch_gnt",   32'(bus.fetch_gnt), 32'd1);
        chk("fetch_rdata", 32'(bus.rdata),     32'hA9);
        chk("fetch_we",    32'(bus.mem_we),    32'd0);
        chk("fetch_addr",  32'(bus.mem_addr),  32'h8000);

        // idle bus
        tick();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 16'h1234;
        #1;
        chk("idle_grants", 32'({bus.fetch_gnt, bus.exec_gnt}), 32'd0);
        chk("idle_we",     32'(bus.mem_we),   32'd0);
        chk("idle_addr",   32'(bus.mem_addr), 32'h1234);

        // exec write beats fetch; fetch granted next cycle
        tick();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h8000;
        bus.exec_req   = 1'b1;
        bus.exec_we    = 1'b1;
        bus.exec_addr  = 16'h0200;
        bus.exec_wdata = 8'h55;
        #1;
        chk("prio_egnt",  32'(bus.exec_gnt),  32'd1);
        chk("prio_fgnt",  32'(bus.fetch_gnt), 32'd0);
        chk("prio_we",    32'(bus.mem_we),    32'd1);
        chk("prio_addr",  32'(bus.mem_addr),  32'h0200);
        chk("prio_wdata", 32'(bus.mem_wdata), 32'h55);
        tick();
        bus.exec_req = 1'b0;
        bus.exec_we  = 1'b0;
        #1;
        chk("held_fgnt", 32'(bus.fetch_gnt), 32'd1);
        chk("held_addr", 32'(bus.mem_addr),  32'h8000);

        // exec read returns memory data in the grant cycle
        tick();
        bus.exec_req  = 1'b1;
        bus.exec_addr = 16'h0200;
        #1;
        chk("eread_gnt",   32'(bus.exec_gnt), 32'd1);
        chk("eread_rdata", 32'(bus.rdata),    32'(mem_model(16'h0200)));

        // read of the DMA register is an ordinary read
        tick();
        bus.exec_addr = 16'h4014;
        #1;
        chk("dmard_gnt",  32'(bus.exec_gnt), 32'd1);
        chk("dmard_we",   32'(bus.mem_we),   32'd0);
        chk("dmard_addr", 32'(bus.mem_addr), 32'h4014);
        tick();
        bus.exec_req = 1'b0;
        #1;
        chk("dmard_halt", 32'({bus.cpu_halt, bus.dma_busy}), 32'd0);
        chk("dmard_fgnt", 32'(bus.fetch_gnt), 32'd1);

        // DMA with HALT on an odd cycle
        tick();
        wait_parity(1'b0);
        trigger(8'h02);
        push_dma(8'h02, 1'b0);
        halted = 0;
        run_sb(600);
        #1;
        chk("odd_halted", 32'(halted), 32'd513);
        chk("odd_end",    32'({bus.cpu_halt, bus.dma_busy}), 32'd0);
        chk("odd_fgnt",   32'(bus.fetch_gnt), 32'd1);

        // DMA with HALT on an even cycle: one ALIGN cycle
        tick();
        wait_parity(1'b1);
        trigger(8'h02);
        push_dma(8'h02, 1'b1);
        halted = 0;
        run_sb(600);
        #1;
        chk("even_halted", 32'(halted), 32'd514);
        chk("even_end",    32'({bus.cpu_halt, bus.dma_busy}), 32'd0);

        // reset in the middle of a DMA, at idx 8'h40
        tick();
        wait_parity(1'b0);
        trigger(8'h05);
        push_dma(8'h05, 1'b0);
        run_sb(129);
        #1;
        chk("mid_addr", 32'(bus.mem_addr), 32'h0540);
        chk("mid_halt", 32'(bus.cpu_halt), 32'd1);
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        chk("mrst_halt",   32'(bus.cpu_halt), 32'd0);
        chk("mrst_busy",   32'(bus.dma_busy), 32'd0);
        chk("mrst_we",     32'(bus.mem_we),   32'd0);
        chk("mrst_grants", 32'({bus.fetch_gnt, bus.exec_gnt}), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_pre_fgnt", 32'(bus.fetch_gnt), 32'd0);
        tick(); #1;
        chk("rel_fgnt", 32'(bus.fetch_gnt), 32'd1);
        chk("rel_halt", 32'(bus.cpu_halt),  32'd0);
        chk("rel_addr", 32'(bus.mem_addr),  32'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, address bus width.
REQ-002 SHALL have parameter REG_WIDTH, default 8, data bus width.
REQ-003 SHALL have parameter OAM_DMA_ADDR, default 16'h4014, DMA trigger register address.
REQ-004 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, DMA write target address.
REQ-005 SHALL use one clock and an asynchronous active-low reset: `phi1  in  1  clock`; `reset_n  in  1  async active-low reset`.
REQ-006 SHALL have `fetch_req  in  1  fetcher bus request`; `fetch_addr  in  ADDR_WIDTH  fetcher read address`; `fetch_gnt  out  1  fetch access performed this cycle`.
REQ-007 SHALL have `exec_req  in  1  execute-unit request`; `exec_we  in  1  write enable`; `exec_addr  in  ADDR_WIDTH  address`; `exec_wdata  in  REG_WIDTH  write data`; `exec_gnt  out  1  exec access performed this cycle`.
REQ-008 SHALL have `mem_addr  out  ADDR_WIDTH`; `mem_wdata  out  REG_WIDTH`; `mem_we  out  1`; `mem_rdata  in  REG_WIDTH  async-read memory data`; `rdata  out  REG_WIDTH  read data to requesters`.
REQ-009 SHALL have `cpu_halt  out  1  stalls fetcher/exec`; `dma_busy  out  1  DMA sequence active`.

Function
REQ-010 SHALL decode grants and the memory mux combinationally from requests and registered state; all state updates on posedge phi1.
REQ-011 SHALL use fixed priority DMA > exec > fetch; at most one grant per cycle.
REQ-012 SHALL, when fetch and exec request together with DMA idle, assert exec_gnt only; fetch_gnt=0, and the fetcher holds its request.
REQ-013 SHALL drive rdata = mem_rdata in the same cycle as a read grant; mem_we=0 on fetch grants.
REQ-014 SHALL, with no request and DMA idle, drive mem_we=0, mem_addr=fetch_addr, both grants 0.
REQ-015 SHALL treat a granted exec write to OAM_DMA_ADDR as the DMA trigger: exec_gnt=1, mem_we=0 (not forwarded), page register <= exec_wdata[7:0].
REQ-016 SHALL keep a parity bit cycle_odd, reset 0, toggling every phi1 edge.
REQ-017 SHALL implement DMA states IDLE, HALT, ALIGN, READ, WRITE.
REQ-018 SHALL transition IDLE->HALT on the edge closing the trigger cycle.
REQ-019 SHALL transition HALT->ALIGN when cycle_odd=0 in HALT, else HALT->READ; ALIGN->READ always; every READ falls on cycle_odd=0.
REQ-020 SHALL in READ drive mem_addr={page,idx}, mem_we=0, latch mem_rdata into dma_byte; READ->WRITE.
REQ-021 SHALL in WRITE drive mem_addr=OAM_DATA_ADDR, mem_wdata=dma_byte, mem_we=1; idx<=idx+1 (8-bit wrap); WRITE->READ if idx!=8'hFF, else WRITE->IDLE with idx wrapping to 0.
REQ-022 SHALL assert cpu_halt and dma_busy in every non-IDLE state; both grants 0 then, whatever the requests.
REQ-023 SHALL hold cpu_halt for exactly 513 cycles (HALT odd) or 514 cycles (HALT even) per DMA.
REQ-024 SHALL ignore exec_addr==OAM_DMA_ADDR reads (normal read, no trigger).

Reset
REQ-025 SHALL, on reset_n=0 (any time, incl. mid-DMA), immediately force IDLE, idx=0, page=0, dma_byte=0, cycle_odd=0, cpu_halt=0, dma_busy=0, mem_we=0, grants 0.
REQ-026 SHALL resume arbitration on the first phi1 edge after reset_n rises.

Structure
REQ-027 SHALL take ADDR_WIDTH, REG_WIDTH, OAM_DMA_ADDR, OAM_DATA_ADDR and DMA state encodings from the shared defines file.
REQ-028 SHALL place the DMA sequencer (states, parity, page/idx/dma_byte) in sub-module oam_dma; the priority mux remains in bus_arbiter.

Verification
REQ-029 SHALL cover: fetch_req=1, fetch_addr=16'h8000, mem_rdata=8'hA9 -> fetch_gnt=1, rdata=8'hA9, mem_we=0 same cycle.
REQ-030 SHALL cover: fetch_req and exec_req (write 8'h55 to 16'h0200) same cycle -> exec_gnt=1, fetch_gnt=0, mem_we=1, mem_addr=16'h0200; fetch granted next cycle.
REQ-031 SHALL cover: exec write 8'h02 to 16'h4014 with HALT odd -> 513 halted cycles; reads 16'h0200..16'h02FF, each followed by a write to 16'h2004 of that byte.
REQ-032 SHALL cover: same trigger with HALT even -> one ALIGN cycle, 514 halted cycles, first READ at cycle_odd=0.
REQ-033 SHALL cover: reset_n pulsed low at DMA idx=8'h40 -> cpu_halt=0, mem_we=0 immediately; a fetch request after release is granted.
REQ-034 SHALL cover: exec read of 16'h4014 -> normal read grant, no halt, dma_busy stays 0.
